// File: rtl/vga_gpu_pkg.sv
// Shared definitions for the VGA GPU command path.
//
// Contents:
//   - 4-bit opcode constants carried in bits [3:0] of every instruction word
//   - issue_state_t : state encoding of the instruction issue FSM
//   - is_sprite()   : true when an instruction word carries SET_SPRITE
package vga_gpu_pkg;

    localparam logic [3:0] SET_BG_COLOR       = 4'h1;
    localparam logic [3:0] SET_RED_BG_COLOR   = 4'h2;
    localparam logic [3:0] SET_GREEN_BG_COLOR = 4'h3;
    localparam logic [3:0] SET_BLUE_BG_COLOR  = 4'h4;
    localparam logic [3:0] SET_PIXEL          = 4'h5;
    localparam logic [3:0] CLEAR_SCREEN       = 4'h6;
    localparam logic [3:0] SET_CURSOR         = 4'h7;
    localparam logic [3:0] SET_SPRITE         = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } issue_state_t;

    function automatic logic is_sprite(input logic [31:0] word);
        return word[3:0] == SET_SPRITE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
//
// Ports:
//   clk, reset  : clock and asynchronous active-high reset (empties the FIFO)
//   push        : write push_data; accepted when not full, or when full and
//                 a pop happens on the same edge
//   pop         : remove the head word (ignored when empty)
//   head        : word at the read pointer, valid whenever empty is 0
//   level       : registered occupancy, 0..DEPTH
//   full, empty : decoded from level
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being vacated by a same-edge pop is the one written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// Instruction queue between the serial command receiver and the pixel
// generator. Bytes are assembled little-endian into 32-bit words, buffered
// in a FIFO and issued one per cycle; after a SET_SPRITE word the issuer
// idles for SPRITE_GAP cycles.
//
// Optional feature: define INSTR_BLANK_GATE_EN to issue words only while
// i_blank is high. Without it i_blank is ignored.
//
// Ports:
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_byte/i_byte_valid : command byte and its one-cycle strobe
//   i_resync            : restart word assembly at byte 0
//   i_blank             : display blanking (gating feature only)
//   i_clear_overflow    : clear the sticky overflow flag
//   o_instruction       : issued word, zero when o_instruction_ready is low
//   o_instruction_ready : one-cycle strobe per issued word
//   o_level, o_full     : FIFO occupancy and full flag
//   o_overflow          : sticky, set when a completed word is dropped
module instruction_queue
    import vga_gpu_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int SPRITE_GAP = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_byte,
    input  logic                   i_byte_valid,
    input  logic                   i_resync,
    input  logic                   i_blank,
    input  logic                   i_clear_overflow,
    output logic [31:0]            o_instruction,
    output logic                   o_instruction_ready,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_overflow
);

    localparam int GW = $clog2(SPRITE_GAP + 1);

    logic [1:0]   byte_cnt;
    logic [1:0]   slot;
    logic [7:0]   byte0;
    logic [7:0]   byte1;
    logic [7:0]   byte2;
    logic         word_done;
    logic [31:0]  word;
    logic [31:0]  head;
    logic         fifo_empty;
    logic         pop;
    logic         blank_ok;
    issue_state_t state;
    logic [GW-1:0] gap_cnt;

`ifdef INSTR_BLANK_GATE_EN
    assign blank_ok = i_blank;
`else
    logic unused_blank;
    assign unused_blank = i_blank;
    assign blank_ok     = 1'b1;
`endif

    // A resync on the same cycle as a byte makes that byte the new byte 0.
    assign slot      = i_resync ? 2'd0 : byte_cnt;
    assign word_done = i_byte_valid && (slot == 2'd3);
    assign word      = {i_byte, byte2, byte1, byte0};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt <= 2'd0;
        end else if (i_byte_valid) begin
            byte_cnt <= slot + 2'd1;
        end else if (i_resync) begin
            byte_cnt <= 2'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_byte_valid) begin
            case (slot)
                2'd0:    byte0 <= i_byte;
                2'd1:    byte1 <= i_byte;
                2'd2:    byte2 <= i_byte;
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (word_done),
        .push_data (word),
        .pop       (pop),
        .head      (head),
        .level     (o_level),
        .full      (o_full),
        .empty     (fifo_empty)
    );

    // While in ISSUE, o_instruction still holds the word being issued, so
    // its opcode decides whether the next pop may happen back-to-back.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = !fifo_empty && blank_ok;
            ST_ISSUE: pop = !is_sprite(o_instruction) && !fifo_empty && blank_ok;
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state               <= ST_IDLE;
            gap_cnt             <= '0;
            o_instruction       <= 32'h0;
            o_instruction_ready <= 1'b0;
        end else begin
            o_instruction_ready <= pop;
            o_instruction       <= pop ? head : 32'h0;
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (is_sprite(o_instruction)) begin
                        state   <= ST_HOLD;
                        gap_cnt <= '0;
                    end else if (!pop) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (gap_cnt == GW'(SPRITE_GAP - 1)) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A drop on the same edge as a clear request keeps the flag set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
        end else if (word_done && o_full && !pop) begin
            o_overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue. A long SPRITE_GAP is used so
// that the FIFO can be filled while the issuer holds after a sprite word.
module tb_instruction_queue;

    localparam int DEPTH = 16;
    localparam int GAP   = 80;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] SPRITE_WORD = 32'h0AB31208;
`ifdef INSTR_BLANK_GATE_EN
    localparam logic BLANK_IDLE = 1'b1;
`else
    localparam logic BLANK_IDLE = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          i_resync;
    logic          i_blank;
    logic          i_clear_overflow;
    logic [31:0]   o_instruction;
    logic          o_instruction_ready;
    logic [LW-1:0] o_level;
    logic          o_full;
    logic          o_overflow;

    always #5 i_clk = ~i_clk;

    instruction_queue #(
        .DEPTH      (DEPTH),
        .SPRITE_GAP (GAP)
    ) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_byte              (i_byte),
        .i_byte_valid        (i_byte_valid),
        .i_resync            (i_resync),
        .i_blank             (i_blank),
        .i_clear_overflow    (i_clear_overflow),
        .o_instruction       (o_instruction),
        .o_instruction_ready (o_instruction_ready),
        .o_level             (o_level),
        .o_full              (o_full),
        .o_overflow          (o_overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int zero_viol = 0;
    logic [31:0] obs_w[$];
    int          obs_t[$];

    // cyc equals k during the cycle that follows rising edge k.
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_instruction_ready) begin
                obs_w.push_back(o_instruction);
                obs_t.push_back(cyc);
            end else if (o_instruction !== 32'h0) begin
                zero_viol <= zero_viol + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs = 1'b0);
        i_byte       = b;
        i_byte_valid = 1'b1;
        i_resync     = rs;
        tick();
        i_byte_valid = 1'b0;
        i_resync     = 1'b0;
        i_byte       = 8'h0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (obs_w.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w[3:0] == 4'h8) w[3:0] = 4'h5;
        return w;
    endfunction

    task automatic clear_obs();
        obs_w.delete();
        obs_t.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        checks++; if (o_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", o_instruction); end
        checks++; if (o_instruction_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_instruction_ready); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", o_level); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
        i_reset = 1'b0;
        tick();
    endtask

    // The fourth byte is presented in the cycle before edge e; the strobe
    // appears in the cycle after edge e+1, two cycles after presentation.
    task automatic test_single();
        int e;
        clear_obs();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h0F); send_byte(8'h00);
        e = cyc;
        checks++; if (o_level !== LW'(1)) begin errors++; $display("FAIL single_level_push: got %0d want 1", o_level); end
        wait_strobes(1, 10);
        checks++;
        if (obs_w.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d strobes want 1", obs_w.size());
        end else begin
            checks++; if (obs_w[0] !== 32'h000F0001) begin errors++; $display("FAIL single_word: got %h want 000F0001", obs_w[0]); end
            checks++; if (obs_t[0] != e + 1) begin errors++; $display("FAIL single_latency: strobe edge %0d want %0d", obs_t[0], e + 1); end
        end
        tick();
        checks++; if (o_level !== '0) begin errors++; $display("FAIL single_level_after: got %0d want 0", o_level); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        clear_obs();
        send_word(SPRITE_WORD);
        for (int i = 0; i < 3; i++) begin
            w[i] = {$urandom_range(32'h0FFF_FFFF, 0), 4'h2};
            send_word(w[i]);
        end
        checks++; if (o_level !== LW'(3)) begin errors++; $display("FAIL b2b_level_hold: got %0d want 3", o_level); end
        wait_strobes(4, GAP + 40);
        checks++;
        if (obs_w.size() != 4) begin
            errors++; $display("FAIL b2b_count: got %0d strobes want 4", obs_w.size());
        end else begin
            checks++; if (obs_w[0] !== SPRITE_WORD) begin errors++; $display("FAIL b2b_sprite: got %h want %h", obs_w[0], SPRITE_WORD); end
            checks++; if (obs_t[1] - obs_t[0] < GAP + 1) begin errors++; $display("FAIL sprite_gap: got %0d cycles want >= %0d", obs_t[1] - obs_t[0], GAP + 1); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs_w[i+1] !== w[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_w[i+1], w[i]); end
            end
            for (int i = 2; i < 4; i++) begin
                checks++; if (obs_t[i] != obs_t[i-1] + 1) begin errors++; $display("FAIL b2b_consecutive%0d: edge %0d want %0d", i, obs_t[i], obs_t[i-1] + 1); end
            end
        end
        tick();
        checks++; if (o_instruction !== 32'h0) begin errors++; $display("FAIL b2b_instr_after: got %h want 0", o_instruction); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL b2b_level_after: got %0d want 0", o_level); end
    endtask

    task automatic test_resync();
        clear_obs();
        send_byte(8'hAA); send_byte(8'hBB);
        i_resync = 1'b1; tick(); i_resync = 1'b0;
        send_word(32'h00000001);
        wait_strobes(1, 10);
        tick(); tick();
        checks++; if (obs_w.size() != 1) begin errors++; $display("FAIL resync_count: got %0d strobes want 1", obs_w.size()); end
        else begin
            checks++; if (obs_w[0] !== 32'h00000001) begin errors++; $display("FAIL resync_word: got %h want 00000001", obs_w[0]); end
        end
        clear_obs();
        send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        wait_strobes(1, 10);
        tick(); tick();
        checks++; if (obs_w.size() != 1) begin errors++; $display("FAIL resync_same_count: got %0d strobes want 1", obs_w.size()); end
        else begin
            checks++; if (obs_w[0] !== 32'h67452301) begin errors++; $display("FAIL resync_same_word: got %h want 67452301", obs_w[0]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] words[$];
        logic [31:0] x;
        int n_sprite;
        int p;
        clear_obs();
`ifdef INSTR_BLANK_GATE_EN
        i_blank  = 1'b0;
        n_sprite = 0;
`else
        send_word(SPRITE_WORD);
        n_sprite = 1;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            x = rand_word();
            words.push_back(x);
            send_word(x);
        end
        checks++; if (o_level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level_full: got %0d want %0d", o_level, DEPTH); end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", o_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
        send_word(rand_word());
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
        checks++; if (o_level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level_drop: got %0d want %0d", o_level, DEPTH); end
        x = rand_word();
        send_byte(x[7:0]); send_byte(x[15:8]); send_byte(x[23:16]);
        i_clear_overflow = 1'b1;
        send_byte(x[31:24]);
        i_clear_overflow = 1'b0;
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_event_wins: got %b want 1", o_overflow); end
        i_clear_overflow = 1'b1; tick(); i_clear_overflow = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", o_overflow); end
        // Land a fourth byte on the edge that pops the first queued word.
`ifdef INSTR_BLANK_GATE_EN
        p = cyc + 4;
`else
        p = (obs_t.size() > 0) ? obs_t[0] + GAP + 2 : cyc;
`endif
        while (cyc < p - 4) tick();
        checks++;
        if (cyc != p - 4) begin
            errors++; $display("FAIL ovf_timing: at edge %0d want %0d", cyc, p - 4);
        end
        x = rand_word();
        send_byte(x[7:0]); send_byte(x[15:8]); send_byte(x[23:16]);
`ifdef INSTR_BLANK_GATE_EN
        i_blank = 1'b1;
`endif
        send_byte(x[31:24]);
        words.push_back(x);
        checks++; if (o_level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_push_pop_level: got %0d want %0d", o_level, DEPTH); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_push_pop_flag: got %b want 0", o_overflow); end
        wait_strobes(n_sprite + DEPTH + 1, 80);
        checks++;
        if (obs_w.size() != n_sprite + DEPTH + 1) begin
            errors++; $display("FAIL ovf_drain_count: got %0d strobes want %0d", obs_w.size(), n_sprite + DEPTH + 1);
        end else begin
            for (int i = 0; i <= DEPTH; i++) begin
                checks++;
                if (obs_w[n_sprite + i] !== words[i]) begin
                    errors++; $display("FAIL ovf_drain_word%0d: got %h want %h", i, obs_w[n_sprite + i], words[i]);
                end
            end
        end
        i_blank = BLANK_IDLE;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] x;
        clear_obs();
        send_word(SPRITE_WORD);
        for (int i = 0; i < 3; i++) send_word(rand_word());
        send_byte(8'h77); send_byte(8'h66);
        checks++; if (o_level !== LW'(3)) begin errors++; $display("FAIL rstmid_level_pre: got %0d want 3", o_level); end
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if (o_instruction !== 32'h0) begin errors++; $display("FAIL rstmid_instr: got %h want 0", o_instruction); end
        checks++; if (o_instruction_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", o_instruction_ready); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", o_level); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b want 0", o_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b want 0", o_overflow); end
        tick();
        i_reset = 1'b0;
        tick();
        for (int i = 0; i < GAP + 20; i++) tick();
        checks++; if (obs_w.size() != 1) begin errors++; $display("FAIL rstmid_no_strobe: got %0d strobes want 1", obs_w.size()); end
        x = rand_word();
        send_word(x);
        wait_strobes(2, 10);
        checks++;
        if (obs_w.size() != 2) begin
            errors++; $display("FAIL rstmid_new_count: got %0d strobes want 2", obs_w.size());
        end else begin
            checks++; if (obs_w[1] !== x) begin errors++; $display("FAIL rstmid_new_word: got %h want %h", obs_w[1], x); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [7:0]  b[4];
        logic [7:0]  by;
        logic        v;
        logic        rs;
        int          cnt = 0;
        int          slot;
        int          n;
        clear_obs();
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom % 10) < 7;
            rs = ($urandom % 20) == 0;
            by = 8'($urandom);
`ifndef INSTR_BLANK_GATE_EN
            i_blank = 1'($urandom);
`endif
            slot = rs ? 0 : cnt;
            if (v && slot == 0 && by[3:0] == 4'h8) by[3:0] = 4'h9;
            i_byte = by; i_byte_valid = v; i_resync = rs;
            tick();
            if (rs) cnt = 0;
            if (v) begin
                b[cnt] = by;
                if (cnt == 3) exp_q.push_back({b[3], b[2], b[1], b[0]});
                cnt = (cnt + 1) % 4;
            end
        end
        i_byte_valid = 1'b0; i_resync = 1'b1; i_byte = 8'h0;
        tick();
        i_resync = 1'b0;
        i_blank  = BLANK_IDLE;
        wait_strobes(exp_q.size(), 20);
        tick(); tick();
        checks++; if (obs_w.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d strobes want %0d", obs_w.size(), exp_q.size()); end
        n = (obs_w.size() < exp_q.size()) ? obs_w.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h want %h", i, obs_w[i], exp_q[i]); end
        end
        checks++; if (zero_viol != 0) begin errors++; $display("FAIL instr_zero_when_idle: got %0d nonzero idle cycles want 0", zero_viol); end
    endtask

    initial begin
        i_reset          = 1'b1;
        i_byte           = 8'h0;
        i_byte_valid     = 1'b0;
        i_resync         = 1'b0;
        i_blank          = BLANK_IDLE;
        i_clear_overflow = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_resync();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
